// File: rtl/lsu_axi_host.sv
// Load/store AXI4-Lite initiator: one outstanding request, store lane steering, load extension.
// Latency: 3 cycles accept-to-RSP_VALID with a zero-wait responder; REQ_READY only in IDLE, no response backpressure.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking their low address bits.
module lsu_axi_host #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_UNSIGNED,
    input  logic [AXI_AWIDTH-1:0] REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [31:0]           RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [AXI_AWIDTH-1:0] HOST_AXI_AWADDR,
    output logic                  HOST_AXI_AWVALID,
    input  logic                  HOST_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0] HOST_AXI_WDATA,
    output logic [3:0]            HOST_AXI_WSTRB,
    output logic                  HOST_AXI_WVALID,
    input  logic                  HOST_AXI_WREADY,
    input  logic [1:0]            HOST_AXI_BRESP,
    input  logic                  HOST_AXI_BVALID,
    output logic                  HOST_AXI_BREADY,
    output logic [AXI_AWIDTH-1:0] HOST_AXI_ARADDR,
    output logic                  HOST_AXI_ARVALID,
    input  logic                  HOST_AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0] HOST_AXI_RDATA,
    input  logic [1:0]            HOST_AXI_RRESP,
    input  logic                  HOST_AXI_RVALID,
    output logic                  HOST_AXI_RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD, S_RD_R, S_DONE} state_t;

    state_t state_q, state_d;

    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [AXI_AWIDTH-1:0] addr_q;
    logic [AXI_DWIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            off_q, size_q;
    logic                  uns_q;

    logic                  accept;
    logic [1:0]            req_size_eff, req_off;
    logic [3:0]            req_wstrb;
    logic [AXI_DWIDTH-1:0] req_wdata;
    logic [31:0]           rd_shift, rd_ext;

    assign accept = (state_q == S_IDLE) && REQ_VALID;

    // Size 3 behaves as word; the lane offset is masked to the access size.
    always_comb begin
        req_size_eff = (REQ_SIZE == 2'd3) ? 2'd2 : REQ_SIZE;
        req_off      = 2'b00;
        req_wstrb    = 4'hF;
        req_wdata    = REQ_WDATA;
        case (req_size_eff)
            2'd0: begin
                req_off   = REQ_ADDR[1:0];
                req_wstrb = 4'b0001 << req_off;
                req_wdata = {4{REQ_WDATA[7:0]}};
            end
            2'd1: begin
                req_off   = {REQ_ADDR[1], 1'b0};
                req_wstrb = 4'b0011 << req_off;
                req_wdata = {2{REQ_WDATA[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misalign;
    assign req_misalign = ((req_size_eff == 2'd1) && REQ_ADDR[0]) ||
                          ((req_size_eff == 2'd2) && (REQ_ADDR[1:0] != 2'b00));
`endif

    always_comb begin
        rd_shift = HOST_AXI_RDATA[31:0] >> {off_q, 3'b000};
        rd_ext   = rd_shift;
        case (size_q)
            2'd0:    rd_ext = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_misalign) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else
`endif
                    if (REQ_WE) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            // AW and W retire independently, in any order.
            S_WR: begin
                awvalid_d = awvalid_q && !HOST_AXI_AWREADY;
                wvalid_d  = wvalid_q && !HOST_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_B;
                    bready_d = 1'b1;
                end
            end
            S_WR_B: begin
                if (HOST_AXI_BVALID) begin
                    state_d     = S_DONE;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (HOST_AXI_BRESP != 2'b00);
                end
            end
            S_RD: begin
                if (HOST_AXI_ARREADY) begin
                    state_d   = S_RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_R: begin
                if (HOST_AXI_RVALID) begin
                    state_d     = S_DONE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rd_ext;
                    rsp_err_d   = (HOST_AXI_RRESP != 2'b00);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture; these only change in IDLE so AXI payloads stay stable until handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'd0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= {REQ_ADDR[AXI_AWIDTH-1:2], 2'b00};
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            off_q   <= req_off;
            size_q  <= req_size_eff;
            uns_q   <= REQ_UNSIGNED;
        end
    end

    assign REQ_READY        = (state_q == S_IDLE);
    assign RSP_VALID        = rsp_valid_q;
    assign RSP_RDATA        = rsp_rdata_q;
    assign RSP_ERR          = rsp_err_q;
    assign HOST_AXI_AWADDR  = addr_q;
    assign HOST_AXI_AWVALID = awvalid_q;
    assign HOST_AXI_WDATA   = wdata_q;
    assign HOST_AXI_WSTRB   = wstrb_q;
    assign HOST_AXI_WVALID  = wvalid_q;
    assign HOST_AXI_BREADY  = bready_q;
    assign HOST_AXI_ARADDR  = addr_q;
    assign HOST_AXI_ARVALID = arvalid_q;
    assign HOST_AXI_RREADY  = rready_q;

endmodule
